// File: rtl/hv_stream_pkg.sv
// Shared definitions for the hypervector item-memory streaming slice.
//   port_mode_e : per-port operating mode (project through item memory / pass-through)
//   Def*        : default widths and depths used by the stream blocks
//   idx_width   : index width for an n-entry structure, never below 1 bit
package hv_stream_pkg;

  typedef enum logic {
    PORT_PROJECT  = 1'b0,
    PORT_PASSTHRU = 1'b1
  } port_mode_e;

  localparam int unsigned DefHvDimension = 512;
  localparam int unsigned DefNumPorts    = 3;
  localparam int unsigned DefImAddrWidth = 10;
  localparam int unsigned DefFifoDepth   = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Non-fall-through FIFO: head always shows the stored oldest entry, so a
// push is visible on head one cycle later at the earliest.
//   clk_sys   : clock
//   rst_b     : asynchronous active-low reset
//   clr       : synchronous clear, empties and zeroes storage, wins over push/pop
//   push      : write push_data (ignored when full, even if popping this cycle)
//   push_data : entry to store
//   pop       : remove head (ignored when empty)
//   head      : stored head entry
//   full/empty/count : occupancy
module fifo_buffer
  import hv_stream_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_sys,
  input  logic                       rst_b,
  input  logic                       clr,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       pop,
  output logic [Width-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic                        do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Fullness is judged before this cycle's pop: no pop-through.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      mem_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (pointer back to requester 0)
//   req_i  : request vector
//   gnt_o  : one-hot grant (combinational), all zero when nothing requests
// After a grant to k, requester (k+1) mod NumReq has highest priority; the
// pointer holds when no grant is issued.
module rr_arbiter
  import hv_stream_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = idx_width(NumReq);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NumReq);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = (idx == PtrW'(NumReq - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/item_memory_stream.sv
// Multi-port item-memory fetch stream. Each port feeds a hold FIFO towards an
// encoder; project-mode ports share one item-memory lookup through a
// round-robin arbiter, pass-through ports push their own hypervector.
//   clk_i, rst_i (sync, active-high), clr_i (sync soft clear), enable_i
//   port_mode_i           : per-port mode, 0 = project, 1 = pass-through
//   lowdim_i/highdim_i    : per-port item address / direct hypervector
//   valid_i/ready_o       : per-port fetch handshake
//   im_addr_o/im_data_i   : shared item-memory lookup (same-cycle data)
//   hv_o/pop_i/stall_o    : per-port FIFO head, pop, pop-on-empty flag
//   count_o               : per-port FIFO occupancy
//   stall_cnt_o           : per-port saturating stall-cycle counter, present
//                           only when ITEM_MEMORY_STREAM_STALL_CNT_EN is defined
module item_memory_stream
  import hv_stream_pkg::*;
#(
  parameter int unsigned HVDimension = DefHvDimension,
  parameter int unsigned NumPorts    = DefNumPorts,
  parameter int unsigned ImAddrWidth = DefImAddrWidth,
  parameter int unsigned FifoDepth   = DefFifoDepth
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clr_i,
  input  logic                                             enable_i,
  input  logic [NumPorts-1:0]                              port_mode_i,
  input  logic [NumPorts-1:0][ImAddrWidth-1:0]             lowdim_i,
  input  logic [NumPorts-1:0][HVDimension-1:0]             highdim_i,
  input  logic [NumPorts-1:0]                              valid_i,
  output logic [NumPorts-1:0]                              ready_o,
  output logic [ImAddrWidth-1:0]                           im_addr_o,
  input  logic [HVDimension-1:0]                           im_data_i,
  output logic [NumPorts-1:0][HVDimension-1:0]             hv_o,
  input  logic [NumPorts-1:0]                              pop_i,
  output logic [NumPorts-1:0]                              stall_o,
  output logic [NumPorts-1:0][$clog2(FifoDepth+1)-1:0]     count_o
`ifdef ITEM_MEMORY_STREAM_STALL_CNT_EN
  ,
  output logic [NumPorts-1:0][31:0]                        stall_cnt_o
`endif
);

  logic                                 fifo_clr;
  logic [NumPorts-1:0]                  is_pass;
  logic [NumPorts-1:0]                  full, empty;
  logic [NumPorts-1:0]                  req, gnt;
  logic [NumPorts-1:0]                  push;
  logic [NumPorts-1:0][HVDimension-1:0] push_data;

  // Hard reset and soft clear take the same path into FIFOs and arbiter.
  assign fifo_clr = rst_i | clr_i;

  // Requests are kept apart from the grant consumers so the arbiter sits
  // between two separate combinational blocks.
  always_comb begin
    is_pass = '0;
    req     = '0;
    for (int p = 0; p < NumPorts; p++) begin
      is_pass[p] = (port_mode_e'(port_mode_i[p]) == PORT_PASSTHRU);
      req[p]     = !is_pass[p] && enable_i && !fifo_clr && valid_i[p] && !full[p];
    end
  end

  rr_arbiter #(
    .NumReq (NumPorts)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (fifo_clr),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    ready_o   = '0;
    push      = '0;
    push_data = '0;
    stall_o   = '0;
    im_addr_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (is_pass[p]) begin
        ready_o[p]   = enable_i && !fifo_clr && !full[p];
        push_data[p] = highdim_i[p];
      end else begin
        ready_o[p]   = gnt[p];
        push_data[p] = im_data_i;
        if (gnt[p]) im_addr_o = lowdim_i[p];
      end
      push[p]    = valid_i[p] && ready_o[p];
      stall_o[p] = pop_i[p] && empty[p];
    end
  end

  // The FIFO's asynchronous reset is held inactive; reset reaches it
  // synchronously through clr alongside the soft clear.
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    fifo_buffer #(
      .Width (HVDimension),
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_sys   (clk_i),
      .rst_b     (1'b1),
      .clr       (fifo_clr),
      .push      (push[p]),
      .push_data (push_data[p]),
      .pop       (pop_i[p]),
      .head      (hv_o[p]),
      .full      (full[p]),
      .empty     (empty[p]),
      .count     (count_o[p])
    );
  end

`ifdef ITEM_MEMORY_STREAM_STALL_CNT_EN
  logic [NumPorts-1:0][31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int p = 0; p < NumPorts; p++) begin
      if (clr_i) stall_cnt_d[p] = '0;
      else if (stall_o[p] && (stall_cnt_q[p] != '1)) stall_cnt_d[p] = stall_cnt_q[p] + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/item_memory_stream.md
ITEM_MEMORY_STREAM -- requirements
Module: item_memory_stream

Interface
REQ-001 SHALL have parameter HVDimension, default 512, hypervector width in bits.
REQ-002 SHALL have parameter NumPorts, default 3, number of independent fetch/encoder channels (>=1).
REQ-003 SHALL have parameter ImAddrWidth, default 10, low-dimensional item address width.
REQ-004 SHALL have parameter FifoDepth, default 2, per-port hold FIFO depth (>=1).
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: clr_i  in  1  synchronous soft clear; enable_i  in  1  system enable; port_mode_i  in  NumPorts  per-port mode, 0=project, 1=pass-through.
REQ-007 SHALL have per-port fetch side: lowdim_i  in  NumPorts x ImAddrWidth; highdim_i  in  NumPorts x HVDimension; valid_i  in  NumPorts; ready_o  out  NumPorts.
REQ-008 SHALL have shared lookup port: im_addr_o  out  ImAddrWidth  address to item memory; im_data_i  in  HVDimension  same-cycle combinational lookup result.
REQ-009 SHALL have encoder side: hv_o  out  NumPorts x HVDimension  FIFO head; pop_i  in  NumPorts; stall_o  out  NumPorts; count_o  out  NumPorts x $clog2(FifoDepth+1)  occupancy.

Function
REQ-010 SHALL hold one FIFO per port, non-fall-through: hv_o shows stored head entry; push visible on hv_o one cycle later at earliest.
REQ-011 SHALL, for pass-through ports, assert ready_o[p] = enable_i && !full[p] and push highdim_i[p] on valid_i[p] && ready_o[p].
REQ-012 SHALL arbitrate among project-mode ports with valid_i high and FIFO not full using round-robin, at most one grant per cycle.
REQ-013 SHALL drive im_addr_o = lowdim_i[granted port], else 0 when no grant; assert ready_o[p] only for granted port (with enable_i); push im_data_i into its FIFO.
REQ-014 SHALL rotate priority after a grant to port k so port (k+1) mod NumPorts is highest next cycle; pointer unchanged with no grant.
REQ-015 SHALL never grant or make ready a port whose FIFO is full, even if pop_i same cycle (no pop-through).
REQ-016 SHALL pop on pop_i[p] && !empty[p]; assert stall_o[p] = pop_i[p] && empty[p] combinationally; a push in the same cycle does not satisfy a pop on an empty FIFO.
REQ-017 SHALL, on simultaneous push and pop on a non-empty non-full FIFO, keep count_o unchanged and advance head.
REQ-018 SHALL wrap read/write pointers modulo FifoDepth; count_o saturates structurally at FifoDepth (full) and 0 (empty).
REQ-019 SHALL, with enable_i low, hold all ready_o at 0 and grant nothing; pops and stall_o remain active.
REQ-020 SHALL, on mode change mid-stream, keep queued entries; new mode applies from that cycle.

Reset
REQ-021 SHALL, while rst_i high at clk_i edge: empty all FIFOs, zero storage, count_o=0, hv_o=0, RR pointer=0; ready_o forced 0 during rst_i.
REQ-022 SHALL treat clr_i identically to rst_i for FIFOs and RR pointer; clr_i has priority over same-cycle push/pop.

Configuration
REQ-023 SHALL, with ITEM_MEMORY_STREAM_STALL_CNT_EN defined, add output stall_cnt_o  out  NumPorts x 32, per-port saturating count of cycles with stall_o[p] high, cleared by rst_i/clr_i.
REQ-024 SHALL, without the macro, omit stall_cnt_o and its registers entirely.

Structure
REQ-025 SHALL place port-mode typedef (PORT_PROJECT=0, PORT_PASSTHRU=1) and default widths in shared package hv_stream_pkg.
REQ-026 SHALL implement the round-robin grant as sub-module rr_arbiter (NumReq parameter, req/gnt one-hot, sync active-high reset); FIFOs reuse the codebase fifo_buffer with a local reset adapter.

Verification
REQ-027 SHALL check: reset then enable_i=1, all ports project, valid_i=3'b111 -> grants ports 0,1,2,0 on successive cycles, im_addr_o tracks lowdim_i of granted port.
REQ-028 SHALL check: port 1 pass-through, FifoDepth=2, valid_i[1]=1 for 3 cycles, no pop -> pushes cycles 0,1; ready_o[1]=0 cycle 2; count_o[1]=2.
REQ-029 SHALL check: pop_i[0]=1 on empty FIFO with valid push same cycle -> stall_o[0]=1, entry appears on hv_o[0] next cycle, count_o[0]=1.
REQ-030 SHALL check: FIFO at count 1, push and pop same cycle -> count_o stays 1, hv_o shows new entry.
REQ-031 SHALL check: clr_i asserted with all FIFOs full -> next cycle count_o=0, hv_o=0, next grant goes to port 0.
REQ-032 SHALL check (macro defined): 5 cycles pop_i[2]=1 on empty -> stall_cnt_o[2]=5; clr_i -> 0.
